// File: rtl/hv_bist_pkg.sv
// hv_bist_pkg
//   Shared definitions for the HV logic-BIST scan-register responder.
//   - bist_state_e : responder FSM state encoding
//   - SCAN_IDX_W   : scan index width for the default register count
//   - par_chk_err  : parity check of a read word against its stored bit
package hv_bist_pkg;

  localparam int HV_SCAN_REG_NUM_DFLT = 8;
  localparam int SCAN_IDX_W           = $clog2(HV_SCAN_REG_NUM_DFLT + 1);

  // Widest read word the parity helper accepts. Narrower words are
  // zero-extended by the caller, which leaves the XOR reduction unchanged.
  localparam int PAR_DATA_W_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_RSP  = 3'd3,
    ST_REL  = 3'd4
  } bist_state_e;

  // Returns 1 when data plus stored bit does not have the expected parity.
  // odd_sel = 1: stored bit makes the total count of ones odd.
  // odd_sel = 0: stored bit makes the total count of ones even.
  function automatic logic par_chk_err(input logic [PAR_DATA_W_MAX-1:0] data,
                                       input logic                      par_bit,
                                       input logic                      odd_sel);
    return ((^data) ^ par_bit) != odd_sel;
  endfunction

endpackage

// File: rtl/hv_scan_reg_bist_rsp.sv
// hv_scan_reg_bist_rsp
//   Responder end of the HV logic-BIST scan-register handshake. For every
//   request level from the BIST controller it reads the next scan register
//   from the HV register file, checks the word against its stored parity bit
//   and answers with a one-cycle ack plus error flag. The first failing index
//   of the run is kept for debug readout.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_bist_en             BIST window; low aborts and clears everything
//   i_bist_scan_reg_req   request level, held until ack
//   o_scan_reg_bist_ack   one-cycle response pulse
//   o_scan_reg_bist_err   error flag, valid only with ack
//   o_rd_en / o_rd_addr   register-file read strobe and address
//   i_rd_vld / i_rd_data / i_rd_par   register-file read return
//   o_first_err_vld / o_first_err_idx sticky first-error record
module hv_scan_reg_bist_rsp
  import hv_bist_pkg::*;
#(
  parameter int                     HV_SCAN_REG_NUM = HV_SCAN_REG_NUM_DFLT,
  parameter int                     SCAN_ADDR_W     = 8,
  parameter int                     SCAN_DATA_W     = 8,
  parameter logic [SCAN_ADDR_W-1:0] SCAN_BASE_ADDR  = 8'h20,
  parameter int                     RD_TMO_TH       = 16,
  parameter bit                     PAR_ODD         = 1'b1
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_bist_en,
  input  logic                                       i_bist_scan_reg_req,
  output logic                                       o_scan_reg_bist_ack,
  output logic                                       o_scan_reg_bist_err,
  output logic                                       o_rd_en,
  output logic [SCAN_ADDR_W-1:0]                     o_rd_addr,
  input  logic                                       i_rd_vld,
  input  logic [SCAN_DATA_W-1:0]                     i_rd_data,
  input  logic                                       i_rd_par,
  output logic                                       o_first_err_vld,
  output logic [$clog2(HV_SCAN_REG_NUM+1)-1:0]       o_first_err_idx
);

  localparam int IDX_W = $clog2(HV_SCAN_REG_NUM + 1);
  localparam int TMO_W = $clog2(RD_TMO_TH + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HV_SCAN_REG_NUM);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TMO_TH - 1);

  bist_state_e             state_q, state_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    err_q, err_d;          // result held for RSP
  logic                    ack_q, ack_d;
  logic                    ack_err_q, ack_err_d;
  logic                    rd_en_q, rd_en_d;
  logic [SCAN_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic                    first_err_vld_q, first_err_vld_d;
  logic [IDX_W-1:0]        first_err_idx_q, first_err_idx_d;

  logic                    rd_par_err;

  assign rd_par_err = par_chk_err(PAR_DATA_W_MAX'(i_rd_data), i_rd_par, PAR_ODD);

  always_comb begin
    state_d         = state_q;
    scan_idx_d      = scan_idx_q;
    tmo_cnt_d       = tmo_cnt_q;
    err_d           = err_q;
    ack_d           = 1'b0;
    ack_err_d       = 1'b0;
    rd_en_d         = 1'b0;
    rd_addr_d       = rd_addr_q;
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (i_bist_scan_reg_req) begin
          if (scan_idx_q == IDX_LAST) begin
            // Run already exhausted: answer with an error, no read.
            state_d = ST_RSP;
            err_d   = 1'b1;
          end else begin
            // The strobe and address are registered here so that they
            // are visible during exactly the RD cycle.
            state_d   = ST_RD;
            rd_en_d   = 1'b1;
            rd_addr_d = SCAN_BASE_ADDR + SCAN_ADDR_W'(scan_idx_q);
            tmo_cnt_d = '0;
          end
        end
      end

      ST_RD: begin
        // Read data in the strobe cycle itself is not accepted.
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        // Data valid takes priority over a coinciding timeout.
        if (i_rd_vld) begin
          err_d   = rd_par_err;
          state_d = ST_RSP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_RSP: begin
        ack_d     = 1'b1;
        ack_err_d = err_q;
        if (scan_idx_q != IDX_LAST) begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
        if (err_q && !first_err_vld_q) begin
          first_err_vld_d = 1'b1;
          first_err_idx_d = scan_idx_q;
        end
        state_d = ST_REL;
      end

      ST_REL: begin
        // Hold off until the request level is released so the still-high
        // request after ack does not start another transaction.
        if (!i_bist_scan_reg_req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Closing the BIST window behaves exactly like reset.
    if (!i_bist_en) begin
      state_d         = ST_IDLE;
      scan_idx_d      = '0;
      tmo_cnt_d       = '0;
      err_d           = 1'b0;
      ack_d           = 1'b0;
      ack_err_d       = 1'b0;
      rd_en_d         = 1'b0;
      rd_addr_d       = '0;
      first_err_vld_d = 1'b0;
      first_err_idx_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      scan_idx_q      <= '0;
      tmo_cnt_q       <= '0;
      err_q           <= 1'b0;
      ack_q           <= 1'b0;
      ack_err_q       <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      scan_idx_q      <= scan_idx_d;
      tmo_cnt_q       <= tmo_cnt_d;
      err_q           <= err_d;
      ack_q           <= ack_d;
      ack_err_q       <= ack_err_d;
      rd_en_q         <= rd_en_d;
      rd_addr_q       <= rd_addr_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign o_scan_reg_bist_ack = ack_q;
  assign o_scan_reg_bist_err = ack_err_q;
  assign o_rd_en             = rd_en_q;
  assign o_rd_addr           = rd_addr_q;
  assign o_first_err_vld     = first_err_vld_q;
  assign o_first_err_idx     = first_err_idx_q;

endmodule

// File: tb/tb_hv_scan_reg_bist_rsp.sv
// tb_hv_scan_reg_bist_rsp
//   Self-checking bench for hv_scan_reg_bist_rsp with default parameters.
//   Directed vectors from a table, hand-written abort/reset sequences and a
//   randomized run checked against a behavioural model of the scan run.
module tb_hv_scan_reg_bist_rsp;
  import hv_bist_pkg::*;

  localparam int NUM    = 8;
  localparam int TMO_TH = 16;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  req;
  logic                  o_ack;
  logic                  o_err;
  logic                  o_rd_en;
  logic [7:0]            o_rd_addr;
  logic                  rd_vld;
  logic [7:0]            rd_data;
  logic                  rd_par;
  logic                  o_fev;
  logic [SCAN_IDX_W-1:0] o_fei;

  int checks;
  int failures;

  // behavioural model of the run: next index and first-error record
  int                    m_idx;
  logic                  m_fev;
  logic [SCAN_IDX_W-1:0] m_fei;

  hv_scan_reg_bist_rsp dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_bist_en           (en),
    .i_bist_scan_reg_req (req),
    .o_scan_reg_bist_ack (o_ack),
    .o_scan_reg_bist_err (o_err),
    .o_rd_en             (o_rd_en),
    .o_rd_addr           (o_rd_addr),
    .i_rd_vld            (rd_vld),
    .i_rd_data           (rd_data),
    .i_rd_par            (rd_par),
    .o_first_err_vld     (o_fev),
    .o_first_err_idx     (o_fei)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ack"},   int'(o_ack), 0);
    chk({nm, "_err"},   int'(o_err), 0);
    chk({nm, "_rd_en"}, int'(o_rd_en), 0);
    chk({nm, "_addr"},  int'(o_rd_addr), 0);
    chk({nm, "_fev"},   int'(o_fev), 0);
    chk({nm, "_fei"},   int'(o_fei), 0);
  endtask

  // One request/ack transaction. lat = cycles from o_rd_en to i_rd_vld
  // (0 = never). exp_lat = cycles from o_rd_en to ack, -1 = no read expected.
  task automatic run_txn(input string nm, input int lat, input logic [7:0] data,
                         input logic par, input int hold, input logic exp_err,
                         input int exp_lat, input logic exp_fev,
                         input logic [SCAN_IDX_W-1:0] exp_fei, input logic [7:0] exp_addr);
    int cyc, rd_cyc, ack_cyc, n_rd;
    logic got_err, got_fev;
    logic [SCAN_IDX_W-1:0] got_fei;
    logic [7:0] got_addr;
    cyc = 0; rd_cyc = -1; ack_cyc = -1; n_rd = 0;
    got_err = 1'b0; got_fev = 1'b0; got_fei = '0; got_addr = '0;
    @(negedge clk);
    req = 1'b1; rd_data = data; rd_par = par;
    while (ack_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_rd_en) begin
        n_rd++;
        rd_cyc = cyc;
        got_addr = o_rd_addr;
      end
      if (o_ack) begin
        ack_cyc = cyc;
        got_err = o_err;
        got_fev = o_fev;
        got_fei = o_fei;
      end
      rd_vld = (rd_cyc >= 0) && (lat > 0) && (cyc == rd_cyc + lat);
    end
    chk({nm, "_ack_seen"}, int'(ack_cyc >= 0), 1);
    chk({nm, "_rd_count"}, n_rd, (exp_lat >= 0) ? 1 : 0);
    if (exp_lat >= 0 && rd_cyc >= 0 && ack_cyc >= 0) begin
      chk({nm, "_latency"}, ack_cyc - rd_cyc, exp_lat);
      chk({nm, "_addr"}, int'(got_addr), int'(exp_addr));
    end
    chk({nm, "_err"}, int'(got_err), int'(exp_err));
    chk({nm, "_fev"}, int'(got_fev), int'(exp_fev));
    chk({nm, "_fei"}, int'(got_fei), int'(exp_fei));
    // request stays high for the cycle after ack plus 'hold' extra cycles
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      rd_vld = 1'b0;
      chk({nm, "_rel_quiet"}, int'({o_ack, o_rd_en}), 0);
    end
    req = 1'b0;
    @(negedge clk);
    chk({nm, "_post_quiet"}, int'({o_ack, o_rd_en}), 0);
    $display("txn %s addr=%02h lat=%0d err=%0d fev=%0d fei=%0d", nm, got_addr,
             (rd_cyc >= 0 && ack_cyc >= 0) ? ack_cyc - rd_cyc : -1, got_err, got_fev, got_fei);
  endtask

  function automatic logic ref_err(input int idx, input int lat, input logic [7:0] data,
                                   input logic par);
    if (idx >= NUM) return 1'b1;
    if (lat < 1 || lat > TMO_TH) return 1'b1;
    // good word: ones in data plus stored bit is an odd count
    return ($countones({data, par}) % 2) == 0;
  endfunction

  task automatic model_txn(input string nm, input int lat, input logic [7:0] data,
                           input logic par, input int hold);
    logic e;
    int   l;
    e = ref_err(m_idx, lat, data, par);
    if (m_idx >= NUM) l = -1;
    else if (lat >= 1 && lat <= TMO_TH) l = lat + 2;
    else l = TMO_TH + 2;
    if (e && !m_fev) begin
      m_fev = 1'b1;
      m_fei = SCAN_IDX_W'(m_idx);
    end
    run_txn(nm, lat, data, par, hold, e, l, m_fev, m_fei, 8'h20 + 8'(m_idx));
    if (m_idx < NUM) m_idx++;
  endtask

  task automatic restart(input string nm);
    @(negedge clk);
    en = 1'b0; req = 1'b0; rd_vld = 1'b0;
    @(negedge clk);
    chk_idle_outputs(nm);
    en = 1'b1;
    m_idx = 0; m_fev = 1'b0; m_fei = '0;
  endtask

  typedef struct {
    bit                    restart;
    int                    lat;
    logic [7:0]            data;
    logic                  par;
    int                    hold;
    logic                  exp_err;
    int                    exp_lat;
    logic                  exp_fev;
    logic [SCAN_IDX_W-1:0] exp_fei;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int row_idx;
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; req = 1'b0; rd_vld = 1'b0; rd_data = '0; rd_par = 1'b0;
    m_idx = 0; m_fev = 1'b0; m_fei = '0;

    // run A: eight good registers, latency 1, then a ninth request
    vecs.push_back('{1'b1, 1, 8'h00, 1'b1, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h01, 1'b0, 3, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h03, 1'b1, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h07, 1'b0, 1, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h0F, 1'b1, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'hA5, 1'b1, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'hFF, 1'b1, 2, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h80, 1'b0, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h00, 1'b1, 0, 1'b1, -1, 1'b1, 4'd8});
    // run B: parity error at 3, vld/timeout coincide at 4, second error at 6
    vecs.push_back('{1'b1, 1, 8'h11, 1'b1, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 5, 8'h3C, 1'b1, 0, 1'b0, 7, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 4, 8'h55, 1'b1, 0, 1'b0, 6, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h01, 1'b1, 0, 1'b1, 3, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 16, 8'h7F, 1'b0, 0, 1'b0, 18, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 2, 8'h00, 1'b1, 0, 1'b0, 4, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 1, 8'hFF, 1'b0, 0, 1'b1, 3, 1'b1, 4'd3});
    vecs.push_back('{1'b0, 3, 8'h81, 1'b1, 0, 1'b0, 5, 1'b1, 4'd3});
    // run C: read never returns at index 2
    vecs.push_back('{1'b1, 1, 8'h00, 1'b1, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 1, 8'h01, 1'b0, 0, 1'b0, 3, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 0, 8'h00, 1'b1, 0, 1'b1, 18, 1'b1, 4'd2});
    vecs.push_back('{1'b0, 1, 8'h0F, 1'b1, 0, 1'b0, 3, 1'b1, 4'd2});

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    row_idx = 0;
    foreach (vecs[i]) begin
      if (vecs[i].restart) begin
        restart($sformatf("restart_row%0d", i));
        row_idx = 0;
      end
      run_txn($sformatf("vec%0d", i), vecs[i].lat, vecs[i].data, vecs[i].par, vecs[i].hold,
              vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_fev, vecs[i].exp_fei,
              8'h20 + 8'(row_idx));
      row_idx++;
    end

    // abort during WAIT at index 5, late read data afterwards
    restart("abort_pre");
    model_txn("abort_t0", 1, 8'h01, 1'b1, 0);
    for (int k = 1; k < 5; k++) model_txn($sformatf("abort_t%0d", k), 1, 8'h10, 1'b0, 0);
    @(negedge clk); req = 1'b1; rd_data = 8'h01; rd_par = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", int'(o_rd_en), 1);
    chk("abort_rd_addr", int'(o_rd_addr), 8'h25);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk_idle_outputs("abort_clear");
    en = 1'b1; req = 1'b0;
    @(negedge clk);
    rd_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rd_vld = 1'b0;
      chk($sformatf("abort_no_ack%0d", k), int'({o_ack, o_rd_en}), 0);
    end
    m_idx = 0; m_fev = 1'b0; m_fei = '0;
    model_txn("abort_after", 1, 8'h01, 1'b0, 0);
    $display("txn abort_sequence done");

    // reset while in RSP with a failing read
    restart("rst_pre");
    @(negedge clk); req = 1'b1; rd_data = 8'h01; rd_par = 1'b1;
    @(negedge clk);
    chk("rst_rd_en", int'(o_rd_en), 1);
    @(negedge clk); rd_vld = 1'b1;
    @(negedge clk); rd_vld = 1'b0;
    chk("rst_rsp_no_ack_yet", int'(o_ack), 0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_mid_rsp");
    rst = 1'b0; req = 1'b0;
    m_idx = 0; m_fev = 1'b0; m_fei = '0;
    model_txn("rst_after", 2, 8'h03, 1'b1, 0);
    $display("txn reset_sequence done");

    // randomized run against the model, including over-count requests
    restart("rand_pre");
    for (int n = 0; n < 40; n++) begin
      int lat;
      if ($urandom_range(0, 11) == 0) restart($sformatf("rand_restart%0d", n));
      lat = ($urandom_range(0, 5) == 0) ? ((($urandom_range(0, 1)) == 0) ? 0 : 17)
                                        : int'($urandom_range(1, 16));
      model_txn($sformatf("rand%0d", n), lat, 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
